axi_native_wr_bridge: RTL and testbench

AXI_NATIVE_WR_BRIDGE -- requirements
Module: axi_native_wr_bridge

---
 rtl/axi_native_wr_bridge_if.sv | 69 ++++++
 rtl/axi_native_wr_bridge.sv | 152 +++++++++++++++
 tb/tb_axi_native_wr_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_native_wr_bridge_if.sv
// Bus bundle for axi_native_wr_bridge.
// Carries the AXI write-address, write-data and write-response channels together with the
// native command and native write-data initiator channels.
//   slave  : bridge side (accepts AXI writes, initiates native commands/data)
//   master : environment side (issues AXI writes, sinks native commands/data)
interface axi_native_wr_bridge_if #(
  parameter int unsigned NATIVE_AW = 26
);
  // AXI write address
  logic                 axi_aw_valid;
  logic                 axi_aw_ready;
  logic [31:0]          axi_aw_payload_addr;
  logic [1:0]           axi_aw_payload_burst;
  logic [7:0]           axi_aw_payload_len;
  logic [3:0]           axi_aw_payload_size;
  logic                 axi_aw_payload_id;
  // AXI write data
  logic                 axi_w_valid;
  logic                 axi_w_ready;
  logic                 axi_w_last;
  logic [255:0]         axi_w_payload_data;
  logic [31:0]          axi_w_payload_strb;
  // AXI write response
  logic                 axi_b_valid;
  logic                 axi_b_ready;
  logic [1:0]           axi_b_payload_resp;
  logic                 axi_b_payload_id;
  // Native command
  logic                 native_cmd_valid;
  logic                 native_cmd_ready;
  logic                 native_cmd_payload_we;
  logic                 native_cmd_payload_mw;
  logic [NATIVE_AW-1:0] native_cmd_payload_addr;
  // Native write data
  logic                 wdata_valid;
  logic                 wdata_ready;
  logic [255:0]         wdata_payload_data;
  logic [31:0]          wdata_payload_we;

  modport slave (
    input  axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_burst, axi_aw_payload_len,
           axi_aw_payload_size, axi_aw_payload_id,
    output axi_aw_ready,
    input  axi_w_valid, axi_w_last, axi_w_payload_data, axi_w_payload_strb,
    output axi_w_ready,
    output axi_b_valid, axi_b_payload_resp, axi_b_payload_id,
    input  axi_b_ready,
    output native_cmd_valid, native_cmd_payload_we, native_cmd_payload_mw,
           native_cmd_payload_addr,
    input  native_cmd_ready,
    output wdata_valid, wdata_payload_data, wdata_payload_we,
    input  wdata_ready
  );

  modport master (
    output axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_burst, axi_aw_payload_len,
           axi_aw_payload_size, axi_aw_payload_id,
    input  axi_aw_ready,
    output axi_w_valid, axi_w_last, axi_w_payload_data, axi_w_payload_strb,
    input  axi_w_ready,
    input  axi_b_valid, axi_b_payload_resp, axi_b_payload_id,
    output axi_b_ready,
    input  native_cmd_valid, native_cmd_payload_we, native_cmd_payload_mw,
           native_cmd_payload_addr,
    output native_cmd_ready,
    input  wdata_valid, wdata_payload_data, wdata_payload_we,
    output wdata_ready
  );
endinterface

// File: rtl/axi_native_wr_bridge.sv
// AXI write slave to native command/write-data bridge, one burst in flight.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-low reset
//   bus : axi_native_wr_bridge_if.slave (AXI AW/W/B slave, native cmd/wdata initiator)
// Each AXI beat becomes one native write command (we=1, mw=0) on a 32-byte word address;
// write data is forwarded combinationally, only once its command has been accepted.
// Unsupported bursts (size!=5, reserved burst type, illegal WRAP length) are drained and
// answered with SLVERR without touching the native side.
module axi_native_wr_bridge #(
  parameter int unsigned ADDR_SHIFT = 5,
  parameter int unsigned NATIVE_AW  = 26
) (
  input logic                   clk,
  input logic                   rst,
  axi_native_wr_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] BurstWrap = 2'b10;
  localparam logic [1:0] BurstRsvd = 2'b11;

  state_e               r_state, w_state_next;
  logic [NATIVE_AW-1:0] r_addr, w_addr_next, w_wrap_mask;
  logic [1:0]           r_burst;
  logic [7:0]           r_len;
  logic                 r_id, r_err, r_last_err;
  logic [8:0]           r_beats_total, r_cmd_cnt, r_w_cnt;
  logic                 w_aw_hs, w_cmd_hs, w_w_hs, w_b_hs;
  logic                 w_aw_err, w_fwd_ok, w_last_beat;
  logic                 w_unused_addr;

  assign w_aw_hs  = bus.axi_aw_valid & bus.axi_aw_ready;
  assign w_cmd_hs = bus.native_cmd_valid & bus.native_cmd_ready;
  assign w_w_hs   = bus.axi_w_valid & bus.axi_w_ready;
  assign w_b_hs   = bus.axi_b_valid & bus.axi_b_ready;

  // Only the word-address field of the byte address is meaningful here.
  assign w_unused_addr = ^bus.axi_aw_payload_addr;

  assign w_aw_err = (bus.axi_aw_payload_size != 4'd5) |
                    (bus.axi_aw_payload_burst == BurstRsvd) |
                    ((bus.axi_aw_payload_burst == BurstWrap) &
                     !(bus.axi_aw_payload_len inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Data may only go out for beats whose command has already been accepted.
  assign w_fwd_ok    = r_cmd_cnt > r_w_cnt;
  assign w_last_beat = (r_w_cnt == r_beats_total - 9'd1);

  // WRAP lengths are restricted to 2^n-1, so len doubles as the in-window offset mask.
  assign w_wrap_mask = NATIVE_AW'(r_len);

  always_comb begin
    w_addr_next = r_addr;
    case (r_burst)
      BurstIncr: w_addr_next = r_addr + 1'b1;
      BurstWrap: w_addr_next = (r_addr & ~w_wrap_mask) | ((r_addr + 1'b1) & w_wrap_mask);
      default:   w_addr_next = r_addr;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_aw_hs) w_state_next = StBurst;
      StBurst: if (w_w_hs && w_last_beat) w_state_next = StResp;
      StResp:  if (w_b_hs) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.axi_aw_ready     = 1'b0;
    bus.axi_w_ready      = 1'b0;
    bus.axi_b_valid      = 1'b0;
    bus.native_cmd_valid = 1'b0;
    bus.wdata_valid      = 1'b0;
    case (r_state)
      // Gated by rst so nothing is accepted while reset is still held.
      StIdle: bus.axi_aw_ready = rst;
      StBurst: begin
        if (r_err) begin
          bus.axi_w_ready = 1'b1;
        end else begin
          bus.native_cmd_valid = r_cmd_cnt < r_beats_total;
          bus.wdata_valid      = bus.axi_w_valid & w_fwd_ok;
          bus.axi_w_ready      = bus.wdata_ready & w_fwd_ok;
        end
      end
      StResp:  bus.axi_b_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.axi_b_payload_id        = r_id;
  assign bus.axi_b_payload_resp      = (r_err | r_last_err) ? 2'b10 : 2'b00;
  assign bus.native_cmd_payload_we   = 1'b1;
  assign bus.native_cmd_payload_mw   = 1'b0;
  assign bus.native_cmd_payload_addr = r_addr;
  assign bus.wdata_payload_data      = bus.axi_w_payload_data;
  assign bus.wdata_payload_we        = bus.axi_w_payload_strb;

  // Burst context and beat counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr        <= '0;
      r_burst       <= '0;
      r_len         <= '0;
      r_id          <= 1'b0;
      r_err         <= 1'b0;
      r_last_err    <= 1'b0;
      r_beats_total <= '0;
      r_cmd_cnt     <= '0;
      r_w_cnt       <= '0;
    end else if (w_aw_hs) begin
      r_addr        <= bus.axi_aw_payload_addr[ADDR_SHIFT+NATIVE_AW-1:ADDR_SHIFT];
      r_burst       <= bus.axi_aw_payload_burst;
      r_len         <= bus.axi_aw_payload_len;
      r_id          <= bus.axi_aw_payload_id;
      r_err         <= w_aw_err;
      r_last_err    <= 1'b0;
      r_beats_total <= {1'b0, bus.axi_aw_payload_len} + 9'd1;
      r_cmd_cnt     <= '0;
      r_w_cnt       <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= w_addr_next;
        r_cmd_cnt <= r_cmd_cnt + 9'd1;
      end
      if (w_w_hs) begin
        r_w_cnt <= r_w_cnt + 9'd1;
        // WLAST must mark exactly the beat that len says is final.
        if (bus.axi_w_last != w_last_beat) r_last_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_native_wr_bridge.sv
module tb_axi_native_wr_bridge;
  localparam int unsigned NAW = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_native_wr_bridge_if #(.NATIVE_AW(NAW)) bus_if ();

  axi_native_wr_bridge #(
    .ADDR_SHIFT(5),
    .NATIVE_AW (NAW)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus_if.slave)
  );

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
  } wbeat_t;
  typedef struct packed {
    logic       id;
    logic [1:0] resp;
  } bresp_t;

  logic [NAW-1:0] exp_cmd_q[$];
  wbeat_t         exp_w_q[$];
  bresp_t         exp_b_q[$];

  int checks = 0;
  int failures = 0;
  int cmd_hs_n = 0;
  int w_hs_n = 0;
  int axw_hs_n = 0;
  int cur_beats = 0;
  int b_done_n = 0;
  int rdy_pct = 100;
  int cmd_hold = 0;
  int b_hold = 0;
  bit b_hold_req = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address of beat i, from the burst rules in plain arithmetic.
  function automatic logic [NAW-1:0] model_addr(input logic [NAW-1:0] base,
                                                 input logic [1:0] burst, input int len,
                                                 input int i);
    longint unsigned b, n, r;
    b = base;
    n = len + 1;
    case (burst)
      2'b00:   r = b;
      2'b01:   r = (b + i) % (64'd1 << NAW);
      default: r = (b / n) * n + ((b % n) + i) % n;
    endcase
    return NAW'(r);
  endfunction

  // Ready generators
  initial begin
    bus_if.native_cmd_ready = 1'b0;
    bus_if.wdata_ready = 1'b0;
    bus_if.axi_b_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cmd_hold > 0) begin
        bus_if.native_cmd_ready = 1'b0;
        cmd_hold--;
      end else begin
        bus_if.native_cmd_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      bus_if.wdata_ready = ($urandom_range(0, 99) < rdy_pct);
      if (b_hold_req && bus_if.axi_b_valid) begin
        b_hold_req = 1'b0;
        b_hold = 4;
      end
      if (b_hold > 0) begin
        bus_if.axi_b_ready = 1'b0;
        b_hold--;
      end else begin
        bus_if.axi_b_ready = ($urandom_range(0, 99) < rdy_pct);
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    int c0, w0;
    if (rst_n) begin
      c0 = cmd_hs_n;
      w0 = w_hs_n;
      if (bus_if.native_cmd_valid) begin
        check("cmd_expected", exp_cmd_q.size() != 0, 1);
        check("aw_ready_busy", bus_if.axi_aw_ready, 0);
        if (bus_if.native_cmd_ready && exp_cmd_q.size() != 0) begin
          check("cmd_addr", bus_if.native_cmd_payload_addr, exp_cmd_q.pop_front());
          check("cmd_we_mw", {bus_if.native_cmd_payload_we, bus_if.native_cmd_payload_mw}, 2'b10);
          cmd_hs_n++;
        end
      end
      if (bus_if.wdata_valid) begin
        check("wdata_after_cmd", c0 > w0, 1);
        check("wdata_expected", exp_w_q.size() != 0, 1);
        if (bus_if.wdata_ready && exp_w_q.size() != 0) begin
          wbeat_t e;
          e = exp_w_q.pop_front();
          check("wdata_data", bus_if.wdata_payload_data, e.data);
          check("wdata_we", bus_if.wdata_payload_we, e.strb);
          w_hs_n++;
        end
      end
      if (bus_if.axi_w_valid && bus_if.axi_w_ready) axw_hs_n++;
      if (bus_if.axi_b_valid) begin
        check("b_expected", exp_b_q.size() != 0, 1);
        check("b_after_all_beats", axw_hs_n, cur_beats);
        check("ready_in_resp", {bus_if.axi_aw_ready, bus_if.axi_w_ready}, 2'b00);
        if (exp_b_q.size() != 0) begin
          check("b_id_resp", {bus_if.axi_b_payload_id, bus_if.axi_b_payload_resp},
                {exp_b_q[0].id, exp_b_q[0].resp});
          if (bus_if.axi_b_ready) begin
            void'(exp_b_q.pop_front());
            b_done_n++;
          end
        end
      end
    end
  end

  // One AXI write burst. last_err_beat >= 0 flips WLAST on that beat; abort_after > 0
  // pulls reset right after that many beats have been accepted.
  task automatic run_burst(input logic [31:0] addr, input logic [1:0] burst, input int len,
                           input logic [3:0] size, input logic id, input int last_err_beat,
                           input int abort_after);
    bit err;
    int nb, b0;
    logic [NAW-1:0] base;
    err = (size != 4'd5) || (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    nb = len + 1;
    base = NAW'(addr >> 5);
    cmd_hs_n = 0;
    w_hs_n = 0;
    axw_hs_n = 0;
    cur_beats = nb;
    if (!err) for (int i = 0; i < nb; i++) exp_cmd_q.push_back(model_addr(base, burst, len, i));
    if (abort_after == 0) exp_b_q.push_back('{id: id, resp: (err || last_err_beat >= 0) ? 2'b10 : 2'b00});
    b0 = b_done_n;

    bus_if.axi_aw_valid = 1'b1;
    bus_if.axi_aw_payload_addr = addr;
    bus_if.axi_aw_payload_burst = burst;
    bus_if.axi_aw_payload_len = 8'(len);
    bus_if.axi_aw_payload_size = size;
    bus_if.axi_aw_payload_id = id;
    @(negedge clk);
    for (int n = 0; n < 50 && !bus_if.axi_aw_ready; n++) @(negedge clk);
    check("aw_accepted", bus_if.axi_aw_ready, 1);
    @(posedge clk);
    #1;
    bus_if.axi_aw_valid = 1'b0;

    for (int i = 0; i < nb; i++) begin
      logic [255:0] d;
      logic [31:0] s;
      int gap;
      gap = (rdy_pct < 100) ? $urandom_range(0, 2) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      s = $urandom;
      if (!err) exp_w_q.push_back('{data: d, strb: s});
      bus_if.axi_w_valid = 1'b1;
      bus_if.axi_w_payload_data = d;
      bus_if.axi_w_payload_strb = s;
      bus_if.axi_w_last = (i == len) ^ (i == last_err_beat);
      @(negedge clk);
      for (int n = 0; n < 200 && !bus_if.axi_w_ready; n++) @(negedge clk);
      check("w_accepted", bus_if.axi_w_ready, 1);
      @(posedge clk);
      #1;
      bus_if.axi_w_valid = 1'b0;
      if (abort_after == i + 1) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valids_low", {bus_if.native_cmd_valid, bus_if.wdata_valid,
                                 bus_if.axi_b_valid, bus_if.axi_w_ready,
                                 bus_if.axi_aw_ready}, 5'b0);
        exp_cmd_q.delete();
        exp_w_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("aw_ready_after_rst", bus_if.axi_aw_ready, 1);
        @(posedge clk);
        #1;
        return;
      end
    end

    for (int n = 0; n < 500 && b_done_n == b0; n++) begin
      @(negedge clk);
      #1;
    end
    check("b_handshake", b_done_n != b0, 1);
    check("cmd_q_drained", exp_cmd_q.size(), 0);
    check("w_q_drained", exp_w_q.size(), 0);
    exp_cmd_q.delete();
    exp_w_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus_if.axi_aw_valid = 1'b0;
    bus_if.axi_aw_payload_addr = '0;
    bus_if.axi_aw_payload_burst = '0;
    bus_if.axi_aw_payload_len = '0;
    bus_if.axi_aw_payload_size = '0;
    bus_if.axi_aw_payload_id = 1'b0;
    bus_if.axi_w_valid = 1'b0;
    bus_if.axi_w_last = 1'b0;
    bus_if.axi_w_payload_data = '0;
    bus_if.axi_w_payload_strb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus_if.axi_aw_ready, bus_if.axi_w_ready, bus_if.axi_b_valid,
                            bus_if.native_cmd_valid, bus_if.wdata_valid}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("aw_ready_after_release", bus_if.axi_aw_ready, 1);
    @(posedge clk);
    #1;

    rdy_pct = 100;
    run_burst(32'h0000_0040, 2'b01, 3, 4'd5, 1'b1, -1, 0);   // addrs 2,3,4,5
    run_burst(32'h0000_00A0, 2'b10, 3, 4'd5, 1'b0, -1, 0);   // addrs 5,6,7,4
    run_burst(32'h0000_0100, 2'b01, 1, 4'd4, 1'b1, -1, 0);   // bad size
    cmd_hold = 8;
    run_burst(32'h0001_2340, 2'b01, 3, 4'd5, 1'b0, -1, 0);   // command side stalled
    b_hold_req = 1'b1;
    run_burst(32'h0000_0200, 2'b01, 2, 4'd5, 1'b1, 1, 0);    // early WLAST, B stalled
    run_burst(32'h7FFF_FFE0, 2'b01, 2, 4'd5, 1'b0, -1, 0);   // INCR address rollover
    run_burst(32'h0000_1000, 2'b00, 5, 4'd5, 1'b1, -1, 0);   // FIXED
    run_burst(32'h0000_03A0, 2'b10, 15, 4'd5, 1'b0, -1, 0);  // WRAP 16
    run_burst(32'h0000_03A0, 2'b10, 2, 4'd5, 1'b1, -1, 0);   // illegal WRAP length
    run_burst(32'h0000_0400, 2'b11, 0, 4'd5, 1'b0, -1, 0);   // reserved burst type

    rdy_pct = 70;
    for (int t = 0; t < 40; t++) begin
      int r, len, le;
      logic [1:0] bt;
      logic [3:0] sz;
      r = $urandom_range(0, 9);
      bt = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
      if (bt == 2'b10 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      sz = ($urandom_range(0, 7) == 0) ? 4'd4 : 4'd5;
      le = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      run_burst($urandom, bt, len, sz, 1'($urandom), le, 0);
    end

    rdy_pct = 100;
    run_burst(32'h0000_0800, 2'b01, 3, 4'd5, 1'b1, -1, 1);   // reset mid-burst
    run_burst(32'h0000_0840, 2'b01, 3, 4'd5, 1'b0, -1, 0);   // fresh burst after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
